// File: rtl/ram_dp_port_arbiter.sv
// ram_dp_port_arbiter
//
// Round-robin arbiter that shares a single RAM port between two requesters.
// Each requester raises a level req together with rw/addr/din and holds them
// until it sees a one-cycle ack. The arbiter latches the winner's request,
// drives the RAM for one cycle, waits out the read latency when reading,
// captures the read data into the winner's dout register and pulses ack.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   req_n, rw_n, addr_n,     requester n (n = 1, 2) request, direction
//   din_n                    (1 write, 0 read), address and write data
//   ack_n                    requester n completion pulse (registered)
//   dout_n                   requester n read data, held until its next read
//   ram_rw, ram_addr,        RAM port controls; ram_rw is only high during
//   ram_din                  the access cycle of a write
//   ram_dout                 RAM read data, valid RD_LAT cycles after address
//   busy                     high whenever an access is in progress
//
// Timing, with the request sampled at the edge ending cycle T:
//   write: access in T+1, ack in T+2
//   read : access in T+1, RD_LAT wait cycles, ack in T+2+RD_LAT

module ram_dp_port_arbiter #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned RD_LAT = 1   // 0..3
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req_1,
   input  logic              rw_1,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] din_1,
   output logic              ack_1,
   output logic [DATA_W-1:0] dout_1,

   input  logic              req_2,
   input  logic              rw_2,
   input  logic [ADDR_W-1:0] addr_2,
   input  logic [DATA_W-1:0] din_2,
   output logic              ack_2,
   output logic [DATA_W-1:0] dout_2,

   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,

   output logic              busy
);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StWait,
      StAck
   } state_e;

   // Wait counter start value; the last wait cycle is the one where cnt_q is 0.
   localparam logic [1:0] WaitLoad = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   state_e              state_q, state_d;
   logic                sel_q, sel_d;     // 0: requester 1, 1: requester 2
   logic                last_q, last_d;   // last granted, same encoding as sel
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                ack_1_q, ack_1_d;
   logic                ack_2_q, ack_2_d;
   logic [DATA_W-1:0]   dout_1_q, dout_1_d;
   logic [DATA_W-1:0]   dout_2_q, dout_2_d;

   logic                win;
   logic                done;
   logic                capture;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      last_d   = last_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      din_d    = din_q;
      cnt_d    = cnt_q;
      dout_1_d = dout_1_q;
      dout_2_d = dout_2_q;
      win      = 1'b0;
      done     = 1'b0;
      capture  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_1 || req_2) begin
               // On contention the requester that did not win last time goes.
               win     = (req_1 && req_2) ? ~last_q : req_2;
               sel_d   = win;
               last_d  = win;
               rw_d    = win ? rw_2   : rw_1;
               addr_d  = win ? addr_2 : addr_1;
               din_d   = win ? din_2  : din_1;
               state_d = StAccess;
            end
         end

         StAccess: begin
            if (rw_q) begin
               done    = 1'b1;
               state_d = StAck;
            end else if (RD_LAT == 0) begin
               capture = 1'b1;
               done    = 1'b1;
               state_d = StAck;
            end else begin
               cnt_d   = WaitLoad;
               state_d = StWait;
            end
         end

         StWait: begin
            if (cnt_q == 2'd0) begin
               capture = 1'b1;
               done    = 1'b1;
               state_d = StAck;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end

         StAck: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // ack is registered so it rises together with the ACK state.
      ack_1_d = done & ~sel_q;
      ack_2_d = done & sel_q;

      if (capture) begin
         if (sel_q) begin
            dout_2_d = ram_dout;
         end else begin
            dout_1_d = ram_dout;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         sel_q    <= 1'b0;
         last_q   <= 1'b1;  // requester 2 "last", so requester 1 wins first
         rw_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         cnt_q    <= 2'd0;
         ack_1_q  <= 1'b0;
         ack_2_q  <= 1'b0;
         dout_1_q <= '0;
         dout_2_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         cnt_q    <= cnt_d;
         ack_1_q  <= ack_1_d;
         ack_2_q  <= ack_2_d;
         dout_1_q <= dout_1_d;
         dout_2_q <= dout_2_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // ram_rw is decoded from the state register, so an asynchronous reset
   // during ACCESS removes the write strobe immediately.
   assign ram_rw   = (state_q == StAccess) & rw_q;
   // The latched request only changes on a grant, so the RAM address and
   // data hold their last values while idle.
   assign ram_addr = addr_q;
   assign ram_din  = din_q;
   assign busy     = (state_q != StIdle);

   assign ack_1    = ack_1_q;
   assign ack_2    = ack_2_q;
   assign dout_1   = dout_1_q;
   assign dout_2   = dout_2_q;

endmodule

// File: tb/tb_ram_dp_port_arbiter.sv
// Testbench for ram_dp_port_arbiter: main instance at RD_LAT=1 checked by a
// scoreboard, plus RD_LAT=0 and RD_LAT=3 instances for the latency cases.

module tb_ram_dp_port_arbiter;

   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_1, rw_1, req_2, rw_2;
   logic [14:0] addr_1, addr_2;
   logic [3:0]  din_1, din_2;
   logic        ack_1, ack_2;
   logic [3:0]  dout_1, dout_2;
   logic        ram_rw;
   logic [14:0] ram_addr;
   logic [3:0]  ram_din, ram_dout;
   logic        busy;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // Main RAM model, one cycle read latency.
   logic [3:0] mem [0:32767];
   logic [3:0] rd_q;
   always @(posedge clk) begin
      if (ram_rw) mem[ram_addr] <= ram_din;
      rd_q <= mem[ram_addr];
   end
   assign ram_dout = rd_q;

   ram_dp_port_arbiter #(
      .ADDR_W(15),
      .DATA_W(4),
      .RD_LAT(RD_LAT)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_1    (req_1),
      .rw_1     (rw_1),
      .addr_1   (addr_1),
      .din_1    (din_1),
      .ack_1    (ack_1),
      .dout_1   (dout_1),
      .req_2    (req_2),
      .rw_2     (rw_2),
      .addr_2   (addr_2),
      .din_2    (din_2),
      .ack_2    (ack_2),
      .dout_2   (dout_2),
      .ram_rw   (ram_rw),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .busy     (busy)
   );

   // Latency instances: index 0 -> RD_LAT=0, index 1 -> RD_LAT=3.
   logic [1:0] lreq;
   logic       lrw;
   logic [1:0] lack;
   logic [7:0] ldout;

   for (genvar g = 0; g < 2; g++) begin : g_lat
      localparam int L  = (g == 0) ? 0 : 3;
      localparam int LI = (L == 0) ? 0 : L - 1;
      logic [3:0]  lmem [0:32767];
      logic [3:0]  pipe [0:3];
      logic        l_rw, l_ack1, l_ack2, l_busy;
      logic [14:0] l_addr;
      logic [3:0]  l_din, l_q, l_dout1, l_dout2;

      always @(posedge clk) begin
         if (l_rw) lmem[l_addr] <= l_din;
         pipe[0] <= lmem[l_addr];
         for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
      assign l_q = (L == 0) ? lmem[l_addr] : pipe[LI];

      ram_dp_port_arbiter #(
         .ADDR_W(15),
         .DATA_W(4),
         .RD_LAT(L)
      ) u_lat (
         .clk      (clk),
         .rst      (rst),
         .req_1    (lreq[g]),
         .rw_1     (lrw),
         .addr_1   (15'd250),
         .din_1    (4'd10),
         .ack_1    (l_ack1),
         .dout_1   (l_dout1),
         .req_2    (1'b0),
         .rw_2     (1'b0),
         .addr_2   (15'd0),
         .din_2    (4'd0),
         .ack_2    (l_ack2),
         .dout_2   (l_dout2),
         .ram_rw   (l_rw),
         .ram_addr (l_addr),
         .ram_din  (l_din),
         .ram_dout (l_q),
         .busy     (l_busy)
      );

      assign lack[g]         = l_ack1;
      assign ldout[g*4 +: 4] = l_dout1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------------
   typedef struct {
      int         who;
      bit         is_read;
      logic [3:0] data;
      int         exp_cyc;   // -1: cycle not checked
   } exp_t;

   exp_t       sb_q[$];
   exp_t       e;
   logic [3:0] m_dout1 = 4'd0;
   logic [3:0] m_dout2 = 4'd0;
   bit         prev_ack = 1'b0;
   int         rw_cnt = 0;
   int         ack_cnt = 0;
   int         viol = 0;

   task automatic push_exp(input int who, input bit is_read, input logic [3:0] data,
                           input int exp_cyc);
      exp_t x;
      x.who     = who;
      x.is_read = is_read;
      x.data    = data;
      x.exp_cyc = exp_cyc;
      sb_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ram_rw) rw_cnt++;
         if (ram_rw && !busy) viol++;
         if (ack_1 || ack_2) begin
            ack_cnt++;
            chk("ack_exclusive", {31'd0, ack_1 & ack_2}, 32'd0);
            chk("ack_single_pulse", {31'd0, prev_ack}, 32'd0);
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL ack_unexpected actual=ack_1:%0b,ack_2:%0b expected=no ack",
                        ack_1, ack_2);
            end else begin
               e = sb_q.pop_front();
               chk("ack_who", ack_2 ? 32'd2 : 32'd1, e.who);
               if (e.exp_cyc >= 0) chk("ack_cycle", cyc, e.exp_cyc);
               if (e.is_read) begin
                  if (e.who == 1) m_dout1 = e.data;
                  else            m_dout2 = e.data;
               end
               chk("dout_1", {28'd0, dout_1}, {28'd0, m_dout1});
               chk("dout_2", {28'd0, dout_2}, {28'd0, m_dout2});
            end
         end
         prev_ack = ack_1 || ack_2;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   // Called just after a posedge. For reads, d is the hand-computed read data.
   task automatic do_op(input int n, input bit rw, input logic [14:0] a,
                        input logic [3:0] d, input bit push, input bit keep);
      int c0;
      bit got;
      if (n == 1) begin
         req_1 = 1'b1; rw_1 = rw; addr_1 = a; din_1 = d;
      end else begin
         req_2 = 1'b1; rw_2 = rw; addr_2 = a; din_2 = d;
      end
      c0 = cyc;
      if (push) push_exp(n, !rw, d, c0 + 2 + (rw ? 0 : RD_LAT));
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         got = (n == 1) ? ack_1 : ack_2;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL op_timeout req=%0d actual=no ack expected=ack", n);
      end
      @(posedge clk);
      #1;
      if (!keep) begin
         if (n == 1) req_1 = 1'b0;
         else        req_2 = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      req_1 = 1'b0;
      req_2 = 1'b0;
      sb_q.delete();
      m_dout1  = 4'd0;
      m_dout2  = 4'd0;
      prev_ack = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Drives both latency instances with the same request and checks each ack.
   task automatic lat_op(input bit rw);
      int c0, got0, got3;
      logic [3:0] d0, d3;
      lrw  = rw;
      lreq = 2'b11;
      c0   = cyc;
      got0 = -1;
      got3 = -1;
      d0   = 4'd0;
      d3   = 4'd0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (lack[0] && got0 < 0) begin got0 = cyc; d0 = ldout[3:0]; end
         if (lack[1] && got3 < 0) begin got3 = cyc; d3 = ldout[7:4]; end
         @(posedge clk);
         #1;
         if (got0 >= 0) lreq[0] = 1'b0;
         if (got3 >= 0) lreq[1] = 1'b0;
      end
      lreq = 2'b00;
      chk(rw ? "lat0_wr_ack_cycle" : "lat0_rd_ack_cycle", got0, c0 + 2);
      chk(rw ? "lat3_wr_ack_cycle" : "lat3_rd_ack_cycle", got3, c0 + (rw ? 2 : 5));
      if (!rw) begin
         chk("lat0_rd_dout", {28'd0, d0}, 32'd10);
         chk("lat3_rd_dout", {28'd0, d3}, 32'd10);
      end
   endtask

   initial begin
      int c0, rw0, acks0, bad;
      req_1 = 1'b0; rw_1 = 1'b0; addr_1 = '0; din_1 = '0;
      req_2 = 1'b0; rw_2 = 1'b0; addr_2 = '0; din_2 = '0;
      lreq  = 2'b00; lrw = 1'b0;

      // Reset state
      #12;
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_ack_1",    {31'd0, ack_1},    32'd0);
      chk("rst_ack_2",    {31'd0, ack_2},    32'd0);
      chk("rst_dout_1",   {28'd0, dout_1},   32'd0);
      chk("rst_dout_2",   {28'd0, dout_2},   32'd0);
      chk("rst_ram_rw",   {31'd0, ram_rw},   32'd0);
      chk("rst_ram_addr", {17'd0, ram_addr}, 32'd0);
      chk("rst_ram_din",  {28'd0, ram_din},  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Requester 1 alone: write 250 <- 10, read it back
      rw0 = rw_cnt;
      do_op(1, 1'b1, 15'd250, 4'd10, 1'b1, 1'b0);
      chk("t1_write_rw_cycles", rw_cnt - rw0, 32'd1);
      do_op(1, 1'b0, 15'd250, 4'd10, 1'b1, 1'b0);
      chk("t1_read_no_rw", rw_cnt - rw0, 32'd1);

      // Simultaneous first requests after reset: requester 1 first
      do_reset();
      c0 = cyc;
      push_exp(1, 1'b1, 4'd10, c0 + 3);
      push_exp(2, 1'b0, 4'd0,  c0 + 6);
      fork
         do_op(1, 1'b0, 15'd250, 4'd10, 1'b0, 1'b0);
         do_op(2, 1'b1, 15'd251, 4'd11, 1'b0, 1'b0);
      join
      do_op(2, 1'b0, 15'd251, 4'd11, 1'b1, 1'b0);

      // Continuous contention: strict alternation 1,2,1,2,1,2
      push_exp(1, 1'b0, 4'd0,  -1);
      push_exp(2, 1'b0, 4'd0,  -1);
      push_exp(1, 1'b0, 4'd0,  -1);
      push_exp(2, 1'b1, 4'd11, -1);
      push_exp(1, 1'b1, 4'd10, -1);
      push_exp(2, 1'b0, 4'd0,  -1);
      fork
         begin
            do_op(1, 1'b1, 15'd300, 4'd1,  1'b0, 1'b1);
            do_op(1, 1'b1, 15'd301, 4'd2,  1'b0, 1'b1);
            do_op(1, 1'b0, 15'd250, 4'd10, 1'b0, 1'b0);
         end
         begin
            do_op(2, 1'b1, 15'd310, 4'd3,  1'b0, 1'b1);
            do_op(2, 1'b0, 15'd251, 4'd11, 1'b0, 1'b1);
            do_op(2, 1'b1, 15'd311, 4'd4,  1'b0, 1'b0);
         end
      join

      // Reset during WAIT of a read by requester 2
      req_2 = 1'b1; rw_2 = 1'b0; addr_2 = 15'd251; din_2 = 4'd0;
      repeat (3) @(negedge clk);
      chk("t4_busy_in_wait", {31'd0, busy}, 32'd1);
      chk("t4_dout_2_before", {28'd0, dout_2}, 32'd11);
      rst = 1'b1;
      #1;
      chk("t4_busy_after_rst",   {31'd0, busy},   32'd0);
      chk("t4_ack_2_after_rst",  {31'd0, ack_2},  32'd0);
      chk("t4_dout_2_after_rst", {28'd0, dout_2}, 32'd0);
      req_2    = 1'b0;
      m_dout1  = 4'd0;
      m_dout2  = 4'd0;
      prev_ack = 1'b0;
      acks0    = ack_cnt;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("t4_no_ack", ack_cnt - acks0, 32'd0);

      // Idle safety
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (ram_rw || busy) bad++;
      end
      chk("t5_idle_quiet", bad, 32'd0);
      @(posedge clk);
      #1;

      // Next simultaneous request is won by requester 1
      c0 = cyc;
      push_exp(1, 1'b0, 4'd0, c0 + 2);
      push_exp(2, 1'b0, 4'd0, c0 + 5);
      fork
         do_op(1, 1'b1, 15'd320, 4'd5, 1'b0, 1'b0);
         do_op(2, 1'b1, 15'd321, 4'd6, 1'b0, 1'b0);
      join

      // Readback: contents unchanged by idle and reset
      do_op(1, 1'b0, 15'd250, 4'd10, 1'b1, 1'b0);
      do_op(2, 1'b0, 15'd251, 4'd11, 1'b1, 1'b0);
      do_op(1, 1'b0, 15'd321, 4'd6,  1'b1, 1'b0);
      do_op(2, 1'b0, 15'd300, 4'd1,  1'b1, 1'b0);
      do_op(1, 1'b0, 15'd311, 4'd4,  1'b1, 1'b0);

      // RD_LAT=0 and RD_LAT=3 instances
      lat_op(1'b1);
      lat_op(1'b0);

      chk("sb_drained", sb_q.size(), 32'd0);
      chk("rw_outside_busy", viol, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_dp_port_arbiter.md
Name: ram_dp_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the 32Kx4 RAM (rw=1 write, rw=0 read, write on posedge clk) between two requesters.
- Each requester uses a req/ack handshake. The arbiter latches the winning request, sequences the RAM access, waits out the read latency, returns read data and pulses ack.
- Sits between two client blocks and one RAM port; two instances can front both ports of the dual-port RAM.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 4, RAM data width.
- RD_LAT, 1, cycles from address presented (rw=0) to ram_dout valid. Legal range 0..3.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous active-high reset.
- req_1  input  1  requester 1 access request, level.
- rw_1  input  1  requester 1 direction: 1 write, 0 read.
- addr_1  input  ADDR_W  requester 1 address.
- din_1  input  DATA_W  requester 1 write data.
- ack_1  output  1  requester 1 completion pulse.
- dout_1  output  DATA_W  requester 1 read data.
- req_2, rw_2, addr_2, din_2, ack_2, dout_2: same as above for requester 2.
- ram_rw  output  1  to RAM rw.
- ram_addr  output  ADDR_W  to RAM address.
- ram_din  output  DATA_W  to RAM data_in.
- ram_dout  input  DATA_W  from RAM data_out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ack_1=ack_2=0; dout_1=dout_2=0; busy=0.
  - ram_rw=0, ram_addr=0, ram_din=0.
  - last_grant=2, so requester 1 wins the first contention.
- States: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - Samples req_1/req_2 each edge.
  - One request high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - On a win: latch sel, rw, addr, din from the winner; last_grant<=winner; next=ACCESS.
  - No request: stay IDLE.
- ACCESS (1 cycle):
  - ram_addr=latched addr, ram_din=latched din, ram_rw=latched rw.
  - Write: RAM writes at end of this cycle; next=ACK.
  - Read with RD_LAT=0: capture ram_dout into dout_sel at end of cycle; next=ACK.
  - Read with RD_LAT>0: next=WAIT, wait counter loaded with RD_LAT-1.
- WAIT:
  - ram_rw=0; ram_addr held at latched addr.
  - Counter decrements each cycle.
  - When counter==0: capture ram_dout into dout_sel; next=ACK.
- ACK (1 cycle):
  - ack_sel=1 for exactly one cycle; other ack stays 0; next=IDLE.
- Output timing and retention:
  - ack_n and dout_n are registered.
  - dout_n holds its value until the next completed read for that requester.
  - Writes never alter dout_n.
- Latency, with req sampled at edge T:
  - Write: ack high in cycle T+2.
  - Read: ack high in cycle T+2+RD_LAT (T+3 at default).
  - Minimum spacing between grants is 3+RD_LAT cycles (read) or 3 cycles (write).
- Requester rules:
  - Hold req, rw, addr and din stable until ack.
  - Drop req in the cycle after ack.
  - req still high in the IDLE cycle after ACK is a new request and is arbitrated normally; round-robin then grants the other requester if both are high.
- ram_rw is 1 only in ACCESS of a write. It is 0 in IDLE, WAIT, ACK and during reset, so the RAM never sees a spurious write.
- In IDLE, ram_addr and ram_din hold their last values.
- Inputs of the losing requester are ignored while busy. Requests arriving while busy are not queued; they are re-evaluated in IDLE.
- Reset mid-operation: the access is abandoned with no ack. A write is suppressed if reset is asserted during ACCESS, because ram_rw drops asynchronously. Arbitration restarts from IDLE with last_grant=2.
- Address and data are passed through unmodified; no wrap or arithmetic.

Test Plan:
- Requester 1 alone: req_1=1, rw_1=1, addr_1=250, din_1=4'd10, then read 250 -> ram_rw=1 for exactly one cycle; write ack_1 at T+2; read ack_1 at T+3 with dout_1=4'b1010; dout_2 stays 0.
- Simultaneous first requests: both req high, requester 2 writes 251 <- 4'd11 -> requester 1 granted first, requester 2 granted on the next IDLE. Reading 251 via requester 2 gives dout_2=4'b1011.
- Continuous contention: both req held high over 6 grants -> grant order strictly alternates 1,2,1,2,1,2; each ack is a single-cycle pulse; ack_1 and ack_2 are never high together.
- Idle safety: no requests for 20 cycles after reset -> ram_rw=0 and busy=0 throughout; previously written RAM contents are unchanged on readback.
- Reset mid-read: assert rst during WAIT of a read by requester 2 -> no ack_2 pulse; dout_2=0; busy=0 immediately. The next simultaneous request is won by requester 1.
- RD_LAT=0 and RD_LAT=3 builds: read of addr 250 -> ack at T+2 and T+5 respectively, with correct dout.
